// File: rtl/bus_drive_arbiter_if.sv
// Bus-side signal bundle between the arbiter and the N tri-state sources.
// master: arbiter side; slave: source/observer side.
interface bus_drive_arbiter_if #(
   parameter int N = 4
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   req;
   logic [N-1:0]   grant;
   logic [N-1:0]   drive_en;
   logic [IDW-1:0] owner_id;
   logic           bus_idle;

   modport master (
      input  req,
      output grant,
      output drive_en,
      output owner_id,
      output bus_idle
   );

   modport slave (
      output req,
      input  grant,
      input  drive_en,
      input  owner_id,
      input  bus_idle
   );
endinterface

// File: rtl/bus_drive_arbiter.sv
// Round-robin arbiter and tri-state enable sequencer: SETUP before DRIVE,
// bounded hold, one all-off TURN cycle between owners. Outputs are registered.
module bus_drive_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bus_drive_arbiter_if.master  bus
);
   localparam int          IDW = (N > 1) ? $clog2(N) : 1;
   localparam int          HW  = $clog2(MAX_HOLD + 1);
   localparam int unsigned NU  = N;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;
   localparam logic [1:0] S_TURN  = 2'd3;

   logic [1:0]     state_q,    state_d;
   logic [IDW-1:0] owner_q,    owner_d;
   logic [IDW-1:0] rr_ptr_q,   rr_ptr_d;
   logic [HW-1:0]  hold_q,     hold_d;
   logic [N-1:0]   grant_q,    grant_d;
   logic [N-1:0]   drive_en_q, drive_en_d;
   logic           bus_idle_q, bus_idle_d;

   logic           arb_found;
   logic [IDW-1:0] arb_idx;
   logic [IDW-1:0] owner_inc;
   logic [N-1:0]   owner_onehot;

   // Circular search starting at rr_ptr; first requester wins.
   always_comb begin
      int unsigned cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int unsigned k = 0; k < NU; k++) begin
         cand = (32'(rr_ptr_q) + k) % NU;
         if (!arb_found && bus.req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = IDW'(cand);
         end
      end
   end

   assign owner_inc = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      case (state_q)
         S_IDLE, S_TURN: begin
            if (arb_found) begin
               owner_d = arb_idx;
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            rr_ptr_d = owner_inc;
            if (bus.req[owner_q]) begin
               state_d = S_DRIVE;
               hold_d  = HW'(1);
            end else begin
               state_d = S_TURN;
            end
         end
         S_DRIVE: begin
            if (!bus.req[owner_q] || hold_q == HW'(MAX_HOLD)) begin
               state_d  = S_TURN;
               rr_ptr_d = owner_inc;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs are decoded from the next state so they land in registers.
   always_comb begin
      for (int unsigned i = 0; i < NU; i++) begin
         owner_onehot[i] = (owner_d == IDW'(i));
      end
      grant_d    = (state_d == S_SETUP || state_d == S_DRIVE) ? owner_onehot : '0;
      drive_en_d = (state_d == S_DRIVE) ? owner_onehot : '0;
      bus_idle_d = ~|drive_en_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         hold_q     <= '0;
         grant_q    <= '0;
         drive_en_q <= '0;
         bus_idle_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_q     <= hold_d;
         grant_q    <= grant_d;
         drive_en_q <= drive_en_d;
         bus_idle_q <= bus_idle_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.drive_en = drive_en_q;
   assign bus.owner_id = owner_q;
   assign bus.bus_idle = bus_idle_q;
endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Self-checking bench for bus_drive_arbiter: directed scenarios plus
// randomized requests against a cycle-level behavioural model.
module tb_bus_drive_arbiter;
   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int IDW      = $clog2(N);
   localparam int W        = 2 * N + IDW + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   bus_drive_arbiter_if #(.N(N)) bus ();

   bus_drive_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: who owns the bus, whether it is in its setup cycle,
   // and how many cycles it has been driving (0 = not driving).
   int m_owner, m_ptr, m_drive;
   bit m_setup;

   function automatic logic [W-1:0] model_out();
      logic [N-1:0] g, d;
      g = '0;
      d = '0;
      if (m_setup || m_drive > 0) g[m_owner] = 1'b1;
      if (m_drive > 0)            d[m_owner] = 1'b1;
      return {g, d, IDW'(m_owner), (d == '0)};
   endfunction

   function automatic logic [W-1:0] observed();
      return {bus.grant, bus.drive_en, bus.owner_id, bus.bus_idle};
   endfunction

   task automatic model_update(input logic [N-1:0] r);
      bit found;
      if (m_setup) begin
         m_setup = 0;
         m_ptr   = (m_owner + 1) % N;
         if (r[m_owner]) m_drive = 1;
      end else if (m_drive > 0) begin
         if (!r[m_owner] || m_drive == MAX_HOLD) begin
            m_drive = 0;
            m_ptr   = (m_owner + 1) % N;
         end else begin
            m_drive++;
         end
      end else if (r != '0) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && r[(m_ptr + k) % N]) begin
               found   = 1;
               m_owner = (m_ptr + k) % N;
               m_setup = 1;
            end
         end
      end
   endtask

   task automatic step();
      model_update(bus.req);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_owner = 0;
      m_ptr   = 0;
      m_drive = 0;
      m_setup = 0;
   endtask

   task automatic test_reset();
      logic [W-1:0] exp;
      do_reset();
      exp = {4'b0000, 4'b0000, 2'd0, 1'b1};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL reset_state: got %b want %b", observed(), exp);
      end
      bus.req = 4'b0001;
      repeat (3) step();
      checks++;
      if (bus.drive_en !== 4'b0001) begin
         errors++;
         $display("FAIL reset_pre_drive: drive_en got %b want 0001", bus.drive_en);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.grant, bus.drive_en, bus.bus_idle} !== {4'b0000, 4'b0000, 1'b1}) begin
         errors++;
         $display("FAIL reset_async: grant/drive_en/idle got %b %b %b want 0000 0000 1",
                  bus.grant, bus.drive_en, bus.bus_idle);
      end
      do_reset();
   endtask

   task automatic test_single();
      logic [N-1:0] eg, ed;
      logic [W-1:0] exp;
      do_reset();
      bus.req = 4'b0001;
      for (int e = 1; e <= 11; e++) begin
         step();
         ed  = (e >= 2 && e <= 9) ? 4'b0001 : 4'b0000;
         eg  = (e <= 9 || e == 11) ? 4'b0001 : 4'b0000;
         exp = {eg, ed, 2'd0, (ed == '0)};
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("FAIL single_edge%0d: got %b want %b", e, observed(), exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int owners[$];
      int run, gap;
      bit seen_run;
      int want[5] = '{0, 1, 2, 3, 0};
      do_reset();
      bus.req  = '1;
      run      = 0;
      gap      = 0;
      seen_run = 0;
      for (int c = 1; c <= 5 * (MAX_HOLD + 2) + 1; c++) begin
         step();
         checks++;
         if (observed() !== model_out()) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got %b want %b", c, observed(), model_out());
         end
         if (bus.drive_en != '0) begin
            if (run == 0) begin
               owners.push_back(int'(bus.owner_id));
               if (seen_run) begin
                  checks++;
                  if (gap != 2) begin
                     errors++;
                     $display("FAIL b2b_gap: got %0d idle cycles want 2", gap);
                  end
               end
            end
            run++;
            gap = 0;
         end else begin
            if (run > 0) begin
               checks++;
               if (run != MAX_HOLD) begin
                  errors++;
                  $display("FAIL b2b_run_len: got %0d want %0d", run, MAX_HOLD);
               end
               seen_run = 1;
            end
            run = 0;
            gap++;
         end
      end
      checks++;
      if (owners.size() != 5) begin
         errors++;
         $display("FAIL b2b_owner_count: got %0d want 5", owners.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (owners[i] != want[i]) begin
               errors++;
               $display("FAIL b2b_owner%0d: got %0d want %0d", i, owners[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_early_release();
      logic [N-1:0] eg, ed;
      logic [W-1:0] exp;
      do_reset();
      bus.req = 4'b0100;
      for (int e = 1; e <= 7; e++) begin
         step();
         ed  = (e >= 2 && e <= 5) ? 4'b0100 : 4'b0000;
         eg  = (e <= 5) ? 4'b0100 : 4'b0000;
         exp = {eg, ed, 2'd2, (ed == '0)};
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("FAIL early_edge%0d: got %b want %b", e, observed(), exp);
         end
         if (e == 5) bus.req = 4'b0000;
      end
      bus.req = '1;
      step();
      checks++;
      if ({bus.grant, bus.owner_id} !== {4'b1000, 2'd3}) begin
         errors++;
         $display("FAIL early_rr_ptr: grant/owner got %b %0d want 1000 3",
                  bus.grant, bus.owner_id);
      end
   endtask

   task automatic test_withdraw();
      logic [W-1:0] exp;
      do_reset();
      bus.req = 4'b0010;
      step();
      bus.req = 4'b0000;
      exp = {4'b0010, 4'b0000, 2'd1, 1'b1};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL withdraw_setup: got %b want %b", observed(), exp);
      end
      for (int e = 2; e <= 4; e++) begin
         step();
         exp = {4'b0000, 4'b0000, 2'd1, 1'b1};
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("FAIL withdraw_edge%0d: got %b want %b", e, observed(), exp);
         end
      end
   endtask

   task automatic test_random();
      int run;
      int bad_model, bad_inv;
      do_reset();
      run       = 0;
      bad_model = 0;
      bad_inv   = 0;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(99) < 30) bus.req = N'($urandom);
         step();
         checks++;
         if (observed() !== model_out()) begin
            errors++;
            bad_model++;
            if (bad_model <= 20)
               $display("FAIL rand_model c%0d: got %b want %b", c, observed(), model_out());
         end
         run = (bus.drive_en != '0) ? run + 1 : 0;
         checks++;
         if ($countones(bus.drive_en) > 1 || $countones(bus.grant) > 1 ||
             (bus.drive_en & ~bus.grant) != '0 || run > MAX_HOLD) begin
            errors++;
            bad_inv++;
            if (bad_inv <= 20)
               $display("FAIL rand_invariant c%0d: grant %b drive_en %b run %0d max %0d",
                        c, bus.grant, bus.drive_en, run, MAX_HOLD);
         end
      end
   endtask

   initial begin
      bus.req = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_early_release();
      test_withdraw();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
